// File: rtl/alu_exec_pkg.sv
// Shared encodings for the execute-stage ALU: AluOp values, R-type function codes,
// the internal operation enum, the control-state constants and the opcode decoder.
package alu_exec_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ADDI  = 2'b11;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_DIVU = 6'b011011;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLL, OP_SRL,
        OP_MFHI, OP_MFLO, OP_MUL, OP_MULU, OP_DIV, OP_DIVU, OP_ILL
    } op_e;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_DIV  = 2'd2;
    localparam state_t ST_HOLD = 2'd3;

    function automatic op_e decode_op(input logic [1:0] alu_op, input logic [5:0] fn);
        op_e op;
        op = OP_ILL;
        case (alu_op)
            ALUOP_ADD, ALUOP_ADDI: op = OP_ADD;
            ALUOP_SUB:             op = OP_SUB;
            default: begin
                case (fn)
                    FN_ADD:   op = OP_ADD;
                    FN_SUB:   op = OP_SUB;
                    FN_AND:   op = OP_AND;
                    FN_OR:    op = OP_OR;
                    FN_NOR:   op = OP_NOR;
                    FN_SLT:   op = OP_SLT;
                    FN_SLL:   op = OP_SLL;
                    FN_SRL:   op = OP_SRL;
                    FN_MFHI:  op = OP_MFHI;
                    FN_MFLO:  op = OP_MFLO;
                    FN_MULT:  op = OP_MUL;
                    FN_MULTU: op = OP_MULU;
                    FN_DIV:   op = OP_DIV;
                    FN_DIVU:  op = OP_DIVU;
                    default:  op = OP_ILL;
                endcase
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply (shift-add) / divide (restoring) engine, one step per clock.
// Works on operand magnitudes and applies the sign fix-up on the way out.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             active_q, active_d;
    logic             dz_q, dz_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_diff;
    logic [2*WIDTH-1:0] prod;

    assign a_neg = is_signed && a[WIDTH-1];
    assign b_neg = is_signed && b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // acc holds the running product high half / partial remainder; x the multiplier / quotient.
    assign mul_sum   = {1'b0, acc_q} + (x_q[0] ? {1'b0, y_q} : '0);
    assign div_shift = {acc_q, x_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, y_q};

    assign done = active_q && (cnt_q == '0);

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        active_d = active_q;
        dz_d     = dz_q;
        div_d    = div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        if (start) begin
            active_d = 1'b1;
            div_d    = is_div;
            neg_d    = a_neg ^ b_neg;
            rneg_d   = a_neg;
            acc_d    = '0;
            x_d      = a_mag;
            y_d      = b_mag;
            cnt_d    = CW'(WIDTH);
            dz_d     = 1'b0;
            if (is_div && (b == '0)) begin
                dz_d  = 1'b1;
                cnt_d = '0;
                acc_d = a;
            end
        end else if (active_q && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
            if (div_q) begin
                if (!div_diff[WIDTH]) begin
                    acc_d = div_diff[WIDTH-1:0];
                    x_d   = {x_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift[WIDTH-1:0];
                    x_d   = {x_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = mul_sum[WIDTH:1];
                x_d   = {mul_sum[0], x_q[WIDTH-1:1]};
            end
        end else if (done) begin
            active_d = 1'b0;
        end
    end

    always_comb begin
        prod = {acc_q, x_q};
        if (neg_q) begin
            prod = -prod;
        end
        hi = prod[2*WIDTH-1:WIDTH];
        lo = prod[WIDTH-1:0];
        if (dz_q) begin
            hi = acc_q;
            lo = '1;
        end else if (div_q) begin
            lo = neg_q ? -x_q : x_q;
            hi = rneg_q ? -acc_q : acc_q;
        end
    end

    // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            dz_q     <= 1'b0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            active_q <= active_d;
            dz_q     <= dz_d;
            div_q    <= div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

endmodule

// File: rtl/alu_exec_seq.sv
// Execute-stage ALU with registered valid/ready result, HI/LO and iterative mult/div.
// Optional signed-overflow flag output enabled by defining ALU_EXEC_OVF_TRAP_EN.
module alu_exec_seq
    import alu_exec_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [5:0]         fn_field,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               busy
`ifdef ALU_EXEC_OVF_TRAP_EN
    ,
    output logic               ovf
`endif
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    op_e              op;
    logic             accept;
    logic             single_accept;
    logic             md_capture;
    logic             md_start, md_is_div, md_is_signed, md_done;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic [WIDTH-1:0] sum, diff, alu_res;

    assign op        = decode_op(alu_op, fn_field);
    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = (result_q == '0);

    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = sum;
            OP_SUB:  alu_res = diff;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_NOR:  alu_res = ~(src_a | src_b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLL:  alu_res = src_b << shamt;
            OP_SRL:  alu_res = src_b >> shamt;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    assign md_start     = accept && ((op == OP_MUL) || (op == OP_MULU) ||
                                     (op == OP_DIV) || (op == OP_DIVU));
    assign md_is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign md_is_signed = (op == OP_MUL) || (op == OP_DIV);

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .is_div    (md_is_div),
        .is_signed (md_is_signed),
        .a         (src_a),
        .b         (src_b),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    always_comb begin
        state_d       = state_q;
        result_d      = result_q;
        out_valid_d   = out_valid_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        single_accept = 1'b0;
        md_capture    = 1'b0;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (md_start) begin
                        state_d = md_is_div ? ST_DIV : ST_MUL;
                    end else begin
                        single_accept = 1'b1;
                        result_d      = alu_res;
                        out_valid_d   = 1'b1;
                    end
                end else if (out_valid_q && !out_ready) begin
                    state_d = ST_HOLD;
                end
            end
            ST_MUL, ST_DIV: begin
                if (md_done) begin
                    md_capture  = 1'b1;
                    result_d    = md_lo;
                    hi_d        = md_hi;
                    lo_d        = md_lo;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

`ifdef ALU_EXEC_OVF_TRAP_EN
    logic ovf_q, ovf_d, alu_ovf;

    // Only R-type add/sub trap; lw/sw/addi/beq arithmetic wraps silently.
    always_comb begin
        alu_ovf = 1'b0;
        if (alu_op == ALUOP_RTYPE) begin
            if (op == OP_ADD) begin
                alu_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
            end else if (op == OP_SUB) begin
                alu_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
            end
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (single_accept) begin
            ovf_d = alu_ovf;
        end else if (md_capture) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: directed cases plus randomized ops against a plain-arithmetic model.
module tb_alu_exec_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   alu_op = 2'b00;
    logic [5:0]   fn_field = 6'b0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic [4:0]   shamt = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;
`ifdef ALU_EXEC_OVF_TRAP_EN
    logic         ovf;
`endif

    int checks = 0;
    int failures = 0;
    logic [W-1:0] mdl_hi = '0;
    logic [W-1:0] mdl_lo = '0;

    alu_exec_seq #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .fn_field  (fn_field),
        .src_a     (src_a),
        .src_b     (src_b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
`ifdef ALU_EXEC_OVF_TRAP_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: result, latency (edges after accept), HI/LO update and overflow from plain arithmetic.
    task automatic model(input logic [1:0] aop, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] sh,
                         output logic [W-1:0] res, output int lat, output bit wr,
                         output logic [W-1:0] nhi, output logic [W-1:0] nlo, output bit eovf);
        longint sa, sb, s, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0; lat = 0; wr = 0; nhi = mdl_hi; nlo = mdl_lo; eovf = 0;
        if (aop == 2'b00 || aop == 2'b11) res = a + b;
        else if (aop == 2'b01) res = a - b;
        else begin
            case (fn)
                6'b100000: begin res = a + b; s = sa + sb; eovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
                6'b100010: begin res = a - b; s = sa - sb; eovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
                6'b100100: res = a & b;
                6'b100101: res = a | b;
                6'b100111: res = ~(a | b);
                6'b101010: res = (sa < sb) ? 1 : 0;
                6'b000000: res = b << sh;
                6'b000010: res = b >> sh;
                6'b010000: res = mdl_hi;
                6'b010010: res = mdl_lo;
                6'b011000: begin p = sa * sb; wr = 1; lat = W + 1; end
                6'b011001: begin p = {32'b0, a} * {32'b0, b}; wr = 1; lat = W + 1; end
                6'b011010: begin
                    wr = 1; lat = W + 1;
                    if (b == 0) begin lat = 1; p = {a, 32'hFFFFFFFF}; end
                    else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
                end
                6'b011011: begin
                    wr = 1; lat = W + 1;
                    if (b == 0) begin lat = 1; p = {a, 32'hFFFFFFFF}; end
                    else p = {a % b, a / b};
                end
                default: res = '0;
            endcase
            if (wr) begin nhi = p[63:32]; nlo = p[31:0]; res = nlo; end
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] aop, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] sh,
                         input logic ordy);
        logic [W-1:0] er, nh, nl;
        int elat, n;
        bit wr, eovf, busy_ok;
        model(aop, fn, a, b, sh, er, elat, wr, nh, nl, eovf);
        @(negedge clk);
        alu_op = aop; fn_field = fn; src_a = a; src_b = b; shamt = sh; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        check({tag, "/in_ready"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = ordy;
        @(negedge clk);
        n = 0; busy_ok = 1;
        while (!out_valid && n < W + 10) begin
            if (!busy || in_ready) busy_ok = 0;
            @(negedge clk);
            n++;
        end
        check({tag, "/latency"}, n, elat);
        check({tag, "/result"}, result, er);
        check({tag, "/zero"}, zero, (er == 0));
        if (elat > 0) check({tag, "/busy"}, busy_ok, 1);
`ifdef ALU_EXEC_OVF_TRAP_EN
        check({tag, "/ovf"}, ovf, eovf);
`endif
        if (wr) begin mdl_hi = nh; mdl_lo = nl; end
    endtask

    logic [5:0] fn_list [15];
    logic [W-1:0] ra, rb;

    initial begin
        fn_list = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010,
                    6'b000000, 6'b000010, 6'b010000, 6'b010010, 6'b011000, 6'b011001,
                    6'b011010, 6'b011011, 6'b111111};

        #12;
        check("rst/out_valid", out_valid, 0);
        check("rst/result", result, 0);
        check("rst/zero", zero, 1);
        check("rst/busy", busy, 0);
        check("rst/in_ready", in_ready, 1);
`ifdef ALU_EXEC_OVF_TRAP_EN
        check("rst/ovf", ovf, 0);
`endif
        @(negedge clk) rst_n = 1'b1;

        do_op("lw_add", 2'b00, 6'h3f, 32'd5, 32'd7, 5'd0, 1'b1);
        do_op("beq_sub", 2'b01, 6'h00, 32'h1234, 32'h1234, 5'd0, 1'b1);
        do_op("mult", 2'b10, 6'b011000, -32'sd3, 32'd4, 5'd0, 1'b1);
        check("mult/lo", result, 32'hFFFFFFF4);
        do_op("mfhi_mult", 2'b10, 6'b010000, 0, 0, 5'd0, 1'b1);
        check("mfhi_mult/val", result, 32'hFFFFFFFF);
        do_op("div0", 2'b10, 6'b011010, 32'd7, 32'd0, 5'd0, 1'b1);
        do_op("mfhi_div0", 2'b10, 6'b010000, 0, 0, 5'd0, 1'b1);
        check("mfhi_div0/val", result, 32'd7);

        do_op("divu_hold", 2'b10, 6'b011011, 32'd100, 32'd7, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold/result", result, 32'd14);
            check("hold/out_valid", out_valid, 1);
            check("hold/in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("hold/released", out_valid, 0);
        do_op("mfhi_divu", 2'b10, 6'b010000, 0, 0, 5'd0, 1'b1);
        check("mfhi_divu/val", result, 32'd2);

        do_op("div_min", 2'b10, 6'b011010, 32'h80000000, 32'hFFFFFFFF, 5'd0, 1'b1);
        check("div_min/lo", result, 32'h80000000);
        do_op("mfhi_min", 2'b10, 6'b010000, 0, 0, 5'd0, 1'b1);
        check("mfhi_min/val", result, 32'd0);
        do_op("div_neg", 2'b10, 6'b011010, -32'sd7, 32'd2, 5'd0, 1'b1);
        do_op("mfhi_neg", 2'b10, 6'b010000, 0, 0, 5'd0, 1'b1);
        do_op("add_ovf", 2'b10, 6'b100000, 32'h7FFFFFFF, 32'd1, 5'd0, 1'b1);
        check("add_ovf/val", result, 32'h80000000);
        do_op("addi_wrap", 2'b11, 6'b100000, 32'h7FFFFFFF, 32'd1, 5'd0, 1'b1);
        do_op("sub_ovf", 2'b10, 6'b100010, 32'h80000000, 32'd1, 5'd0, 1'b1);
        do_op("illegal", 2'b10, 6'b111111, 32'd9, 32'd3, 5'd0, 1'b1);
        do_op("sll31", 2'b10, 6'b000000, 0, 32'd3, 5'd31, 1'b1);
        do_op("srl31", 2'b10, 6'b000010, 0, 32'h80000000, 5'd31, 1'b1);

        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = $urandom_range(0, 3);
                1: ra = 32'h80000000;
                2: rb = 32'hFFFFFFFF;
                default: ;
            endcase
            do_op("rand", 2'($urandom_range(0, 3)), fn_list[$urandom_range(0, 14)],
                  ra, rb, 5'($urandom), 1'b1);
        end
        do_op("rand_mfhi", 2'b10, 6'b010000, 0, 0, 5'd0, 1'b1);
        do_op("rand_mflo", 2'b10, 6'b010010, 0, 0, 5'd0, 1'b1);

        do_op("pre_rst_mult", 2'b10, 6'b011001, 32'd1000, 32'd3000, 5'd0, 1'b1);
        @(negedge clk);
        alu_op = 2'b10; fn_field = 6'b011000; src_a = 32'd12345; src_b = 32'd678; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("mid_mult/busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst/out_valid", out_valid, 0);
        check("mid_rst/result", result, 0);
        check("mid_rst/zero", zero, 1);
        check("mid_rst/busy", busy, 0);
        mdl_hi = '0;
        mdl_lo = '0;
        @(negedge clk) rst_n = 1'b1;
        do_op("mflo_after_rst", 2'b10, 6'b010010, 0, 0, 5'd0, 1'b1);
        check("mflo_after_rst/val", result, 32'd0);
        do_op("mfhi_after_rst", 2'b10, 6'b010000, 0, 0, 5'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
